// File: rtl/return_stack.sv
// LIFO return-address stack feeding the PC parallel-load bus; state advances only on clock-enabled edges.
// Define RETURN_STACK_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module return_stack #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clke,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_err_clr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int                   IDX_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] LAST_C    = CNT_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [CNT_WIDTH-1:0]  top_idx;
  logic [CNT_WIDTH-1:0]  wr_idx;
  logic [CNT_WIDTH-1:0]  wr_sel;
  logic                  do_write;
  logic                  set_ovf;
  logic                  set_unf;

  // Indices stay within 0..DEPTH-1 even for the unreachable edge cases.
  always_comb begin
    top_idx = (cnt == '0) ? '0 : cnt - 1'b1;
    wr_idx  = (cnt >= DEPTH_C) ? LAST_C : cnt;
  end

  // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_nxt  = cnt;
    wr_sel   = wr_idx;
    do_write = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    unique case ({i_push, i_pop})
      2'b10: begin
        if (cnt < DEPTH_C) begin
          do_write = 1'b1;
          cnt_nxt  = cnt + 1'b1;
        end else begin
          set_ovf = 1'b1;
        end
      end
      2'b01: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           set_unf = 1'b1;
      end
      2'b11: begin
        // Replace-top when non-empty; on an empty stack this is a plain push into slot 0.
        do_write = 1'b1;
        if (cnt != '0) wr_sel  = top_idx;
        else           cnt_nxt = cnt + 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset)     cnt <= '0;
    else if (i_clke) cnt <= cnt_nxt;
  end

  // NOTE: entry storage is deliberately not reset; cnt alone defines which entries are valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_clke && do_write) mem[IDX_WIDTH'(wr_sel)] <= i_data;
  end

  assign o_count = cnt;
  assign o_empty = (cnt == '0);
  assign o_full  = (cnt == DEPTH_C);
  assign o_data  = o_empty ? '0 : mem[IDX_WIDTH'(top_idx)];

`ifdef RETURN_STACK_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Set has priority over clear within the same enabled edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (i_clke) begin
      if (set_ovf)        ovf_q <= 1'b1;
      else if (i_err_clr) ovf_q <= 1'b0;
      if (set_unf)        unf_q <= 1'b1;
      else if (i_err_clr) unf_q <= 1'b0;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  logic unused_err;
  assign unused_err  = ^{i_err_clr, set_ovf, set_unf};
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Directed self-checking bench for return_stack (DEPTH=4, DATA_WIDTH=8).
// Flag expectations follow RETURN_STACK_ERR_EN when the bench is compiled with it.
module tb_return_stack;

  localparam int DW = 8;
  localparam int CW = 3;
`ifdef RETURN_STACK_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, clke, push, pop, err_clr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [CW-1:0] count;
  logic          empty, full, ovf, unf;

  int n_vec = 0;
  int n_bad = 0;

  return_stack #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_clke      (clke),
    .i_push      (push),
    .i_pop       (pop),
    .i_err_clr   (err_clr),
    .i_data      (din),
    .o_data      (dout),
    .o_count     (count),
    .o_empty     (empty),
    .o_full      (full),
    .o_overflow  (ovf),
    .o_underflow (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one set of inputs across a single rising edge, then settle away from the edge.
  task automatic cyc(input logic r, input logic ce, input logic pu, input logic po,
                     input logic clr, input logic [DW-1:0] d);
    reset = r; clke = ce; push = pu; pop = po; err_clr = clr; din = d;
    @(posedge clk);
    #1;
    reset = 1'b0; clke = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = '0;
  endtask

  task automatic chk_state(input string tag, input int c, input logic [DW-1:0] d,
                           input logic o, input logic u);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".data"},  32'(dout),  32'(d));
    check({tag, ".empty"}, 32'(empty), 32'(c == 0));
    check({tag, ".full"},  32'(full),  32'(c == 4));
    check({tag, ".ovf"},   32'(ovf),   32'(o));
    check({tag, ".unf"},   32'(unf),   32'(u));
  endtask

  logic [DW-1:0] pops [4];

  initial begin
    reset = 1'b1; clke = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = '0;
    cyc(1, 1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk_state("reset_idle", 0, 8'h00, 0, 0);

    // Reset must act without clock enable.
    cyc(0, 1, 1, 0, 0, 8'h11);
    chk_state("one_push", 1, 8'h11, 0, 0);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk_state("reset_no_clke", 0, 8'h00, 0, 0);

    cyc(0, 1, 1, 0, 0, 8'h11);
    cyc(0, 1, 1, 0, 0, 8'h22);
    cyc(0, 1, 1, 0, 0, 8'h33);
    cyc(0, 1, 1, 0, 0, 8'h44);
    chk_state("fill", 4, 8'h44, 0, 0);

    cyc(0, 1, 1, 0, 0, 8'h55);
    chk_state("push_full", 4, 8'h44, ERR, 0);
    cyc(0, 1, 0, 0, 1, 8'h00);
    chk_state("ovf_clr", 4, 8'h44, 0, 0);
    // Set and clear on the same edge: set wins.
    cyc(0, 1, 1, 0, 1, 8'h56);
    chk_state("ovf_set_wins", 4, 8'h44, ERR, 0);
    cyc(0, 1, 0, 0, 1, 8'h00);

    // Replace-top while full is legal and raises nothing.
    cyc(0, 1, 1, 1, 0, 8'h66);
    chk_state("replace_full", 4, 8'h66, 0, 0);

    pops[0] = 8'h66; pops[1] = 8'h33; pops[2] = 8'h22; pops[3] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop%0d.data_before", i), 32'(dout), 32'(pops[i]));
      cyc(0, 1, 0, 1, 0, 8'h00);
    end
    chk_state("drained", 0, 8'h00, 0, 0);

    cyc(0, 1, 0, 1, 0, 8'h00);
    chk_state("pop_empty", 0, 8'h00, 0, ERR);
    cyc(0, 1, 0, 0, 1, 8'h00);
    chk_state("unf_clr", 0, 8'h00, 0, 0);

    cyc(0, 1, 1, 1, 0, 8'h7A);
    chk_state("pushpop_empty", 1, 8'h7A, 0, 0);

    cyc(0, 1, 0, 1, 0, 8'h00);
    cyc(0, 1, 1, 0, 0, 8'h11);
    cyc(0, 1, 1, 0, 0, 8'h22);
    chk_state("two_deep", 2, 8'h22, 0, 0);
    cyc(0, 1, 1, 1, 0, 8'h99);
    chk_state("replace_top", 2, 8'h99, 0, 0);
    cyc(0, 1, 0, 1, 0, 8'h00);
    chk_state("pop_after_replace", 1, 8'h11, 0, 0);

    cyc(0, 0, 1, 0, 0, 8'hBB);
    chk_state("noclke_push", 1, 8'h11, 0, 0);
    cyc(0, 0, 0, 1, 0, 8'h00);
    chk_state("noclke_pop", 1, 8'h11, 0, 0);
    cyc(0, 0, 1, 1, 0, 8'hCC);
    chk_state("noclke_pushpop", 1, 8'h11, 0, 0);

    cyc(1, 1, 1, 0, 0, 8'hAA);
    chk_state("reset_with_push", 0, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
